lcd_rx: RTL and testbench

Receive-side counterpart of the LCD write driver. Monitors the HD44780-style LCD bus (rs, en, 8-bit data), captures each transfer on the falling edge of en, decodes it, and tracks the controller's address counter and busy window. Each decoded transfer is emitted as an event on a ready/valid stream through a small FIFO. Used as a synthesizable bus monitor and as the responder model in driver testbenches.

---
 rtl/lcd_pkg.sv | 50 +++++
 rtl/lcd_rx_fifo.sv | 45 ++++
 rtl/lcd_rx.sv | 223 ++++++++++++++++++++++
 tb/tb_lcd_rx.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD receive-side monitor.
// Contents: event type codes, busy-timer FSM states, tick lengths, default busy
// windows, DDRAM line-wrap constants and the instruction-byte decoder.
package lcd_pkg;

  typedef enum logic [3:0] {
    EvtNop     = 4'd0,
    EvtClear   = 4'd1,
    EvtHome    = 4'd2,
    EvtEntry   = 4'd3,
    EvtDisplay = 4'd4,
    EvtShift   = 4'd5,
    EvtFunc    = 4'd6,
    EvtCgAddr  = 4'd7,
    EvtDdAddr  = 4'd8,
    EvtChar    = 4'd9,
    EvtCgData  = 4'd10
  } evt_type_e;

  typedef enum logic {StIdle, StBusy} busy_st_e;

  localparam int unsigned TickSlow     = 1024;
  localparam int unsigned TickFast     = 4;
  localparam int unsigned BusyLongDef  = 250;
  localparam int unsigned BusyShortDef = 4;

  // Two-line DDRAM layout: line 0 is 0x00..0x27, line 1 is 0x40..0x67.
  localparam logic [6:0] DdLine0End   = 7'h27;
  localparam logic [6:0] DdLine1Start = 7'h40;
  localparam logic [6:0] DdLine1End   = 7'h67;

  // {type, data, addr}
  localparam int unsigned EvtWidth = 19;

  // Instruction class is given by the highest set bit of the byte.
  function automatic evt_type_e decode_instr(input logic [7:0] b);
    evt_type_e t;
    if (b[7])      t = EvtDdAddr;
    else if (b[6]) t = EvtCgAddr;
    else if (b[5]) t = EvtFunc;
    else if (b[4]) t = EvtShift;
    else if (b[3]) t = EvtDisplay;
    else if (b[2]) t = EvtEntry;
    else if (b[1]) t = EvtHome;
    else if (b[0]) t = EvtClear;
    else           t = EvtNop;
    return t;
  endfunction

endpackage

// File: rtl/lcd_rx_fifo.sv
// Synchronous show-ahead FIFO for decoded LCD events.
// Ports: clk_i, rst_n_i (async active-low), push_i/wdata_i write side,
// pop_i read side, rdata_o head entry (valid when !empty_o), full_o, empty_o.
// A push while full is accepted only when a pop happens in the same cycle.
module lcd_rx_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 19
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned Aw = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [Aw:0]      wr_q, rd_q;
  logic             do_push, do_pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[Aw] != rd_q[Aw]) && (wr_q[Aw-1:0] == rd_q[Aw-1:0]);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign rdata_o = mem_q[rd_q[Aw-1:0]];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q[Aw-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/lcd_rx.sv
// HD44780-style LCD bus monitor: synchronizes rs/en/data, captures a transfer on
// each falling edge of en, decodes it, tracks the address counter and busy
// window, and queues one event per transfer on a ready/valid stream.
// Ports: clk_i, rst_n_i (async active-low); rs_i, en_i, lcd_data_i LCD bus;
// evt_valid_o/evt_ready_i/evt_type_o/evt_data_o/evt_addr_o event stream;
// busy_o emulated busy flag; err_busy_o, err_ovf_o sticky errors; err_clr_i clears them.
// Macro LCD_RX_FAST_SIM_EN: when defined, a busy tick is 4 clocks instead of 1024.
module lcd_rx
  import lcd_pkg::*;
#(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned BUSY_LONG  = BusyLongDef,
  parameter int unsigned BUSY_SHORT = BusyShortDef
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       rs_i,
  input  logic       en_i,
  input  logic [7:0] lcd_data_i,
  output logic       evt_valid_o,
  input  logic       evt_ready_i,
  output logic [3:0] evt_type_o,
  output logic [7:0] evt_data_o,
  output logic [6:0] evt_addr_o,
  output logic       busy_o,
  output logic       err_busy_o,
  output logic       err_ovf_o,
  input  logic       err_clr_i
);

`ifdef LCD_RX_FAST_SIM_EN
  localparam int unsigned TickLen = TickFast;
`else
  localparam int unsigned TickLen = TickSlow;
`endif
  localparam logic [9:0] TickMax = 10'(TickLen - 1);

  // Synchronizers; en_s3_q is the edge-detect history flop.
  logic       rs_s1_q, rs_s2_q, en_s1_q, en_s2_q, en_s3_q;
  logic [7:0] data_s1_q, data_s2_q;
  logic       cap_q, cap_rs_q;
  logic [7:0] cap_data_q;
  logic       en_fall;

  assign en_fall = en_s3_q & ~en_s2_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rs_s1_q    <= 1'b0;
      rs_s2_q    <= 1'b0;
      en_s1_q    <= 1'b0;
      en_s2_q    <= 1'b0;
      en_s3_q    <= 1'b0;
      data_s1_q  <= '0;
      data_s2_q  <= '0;
      cap_q      <= 1'b0;
      cap_rs_q   <= 1'b0;
      cap_data_q <= '0;
    end else begin
      rs_s1_q   <= rs_i;
      rs_s2_q   <= rs_s1_q;
      en_s1_q   <= en_i;
      en_s2_q   <= en_s1_q;
      en_s3_q   <= en_s2_q;
      data_s1_q <= lcd_data_i;
      data_s2_q <= data_s1_q;
      cap_q     <= en_fall;
      if (en_fall) begin
        cap_rs_q   <= rs_s2_q;
        cap_data_q <= data_s2_q;
      end
    end
  end

  // Address counter / entry mode state.
  logic [6:0] addr_q, addr_d;
  logic       id_q, id_d, cg_q, cg_d;
  evt_type_e  cap_type;

  assign cap_type = cap_rs_q ? (cg_q ? EvtCgData : EvtChar) : decode_instr(cap_data_q);

  always_comb begin
    addr_d = addr_q;
    id_d   = id_q;
    cg_d   = cg_q;
    if (cap_q) begin
      case (cap_type)
        EvtClear: begin
          addr_d = '0;
          id_d   = 1'b1;
          cg_d   = 1'b0;
        end
        EvtHome: begin
          addr_d = '0;
          cg_d   = 1'b0;
        end
        EvtEntry: id_d = cap_data_q[1];
        EvtCgAddr: begin
          addr_d = {1'b0, cap_data_q[5:0]};
          cg_d   = 1'b1;
        end
        EvtDdAddr: begin
          addr_d = cap_data_q[6:0];
          cg_d   = 1'b0;
        end
        EvtChar: begin
          if (id_q) begin
            if (addr_q == DdLine0End)      addr_d = DdLine1Start;
            else if (addr_q == DdLine1End) addr_d = 7'h00;
            else                           addr_d = addr_q + 7'd1;
          end else begin
            if (addr_q == DdLine1Start)    addr_d = DdLine0End;
            else if (addr_q == 7'h00)      addr_d = DdLine1End;
            else                           addr_d = addr_q - 7'd1;
          end
        end
        EvtCgData: begin
          addr_d = id_q ? {1'b0, addr_q[5:0] + 6'd1} : {1'b0, addr_q[5:0] - 6'd1};
        end
        default: ;
      endcase
    end
  end

  // Busy timer: prescaler restarts on every capture so each window is exact.
  busy_st_e    st_q, st_d;
  logic [9:0]  pre_q, pre_d;
  logic [15:0] cnt_q, cnt_d, load_q, load_d;

  always_comb begin
    st_d   = st_q;
    pre_d  = pre_q;
    cnt_d  = cnt_q;
    load_d = load_q;
    if (cap_q) begin
      st_d   = StBusy;
      pre_d  = '0;
      cnt_d  = '0;
      load_d = (cap_type == EvtClear || cap_type == EvtHome) ? 16'(BUSY_LONG) : 16'(BUSY_SHORT);
    end else begin
      case (st_q)
        StBusy: begin
          if (pre_q == TickMax) begin
            pre_d = '0;
            cnt_d = cnt_q + 16'd1;
            if (cnt_d == load_q) st_d = StIdle;
          end else begin
            pre_d = pre_q + 10'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy_o = (st_q == StBusy);

  // Event FIFO.
  logic [EvtWidth-1:0] fifo_rdata;
  logic                fifo_full, fifo_empty, pop, push, ovf;

  assign pop  = evt_valid_o & evt_ready_i;
  assign push = cap_q & (~fifo_full | pop);
  assign ovf  = cap_q & fifo_full & ~pop;

  lcd_rx_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(EvtWidth)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_n_i(rst_n_i),
    .push_i (push),
    .wdata_i({cap_type, cap_data_q, addr_q}),
    .pop_i  (pop),
    .rdata_o(fifo_rdata),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  assign evt_valid_o = ~fifo_empty;
  assign evt_type_o  = fifo_empty ? 4'd0 : fifo_rdata[18:15];
  assign evt_data_o  = fifo_empty ? 8'd0 : fifo_rdata[14:7];
  assign evt_addr_o  = fifo_empty ? 7'd0 : fifo_rdata[6:0];

  // Sticky errors; a new error wins over a same-cycle clear.
  logic err_busy_d, err_ovf_d;

  always_comb begin
    err_busy_d = err_busy_o;
    err_ovf_d  = err_ovf_o;
    if (err_clr_i) begin
      err_busy_d = 1'b0;
      err_ovf_d  = 1'b0;
    end
    if (cap_q && busy_o) err_busy_d = 1'b1;
    if (ovf)             err_ovf_d  = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      addr_q     <= '0;
      id_q       <= 1'b1;
      cg_q       <= 1'b0;
      st_q       <= StIdle;
      pre_q      <= '0;
      cnt_q      <= '0;
      load_q     <= '0;
      err_busy_o <= 1'b0;
      err_ovf_o  <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      id_q       <= id_d;
      cg_q       <= cg_d;
      st_q       <= st_d;
      pre_q      <= pre_d;
      cnt_q      <= cnt_d;
      load_q     <= load_d;
      err_busy_o <= err_busy_d;
      err_ovf_o  <= err_ovf_d;
    end
  end

endmodule

// File: tb/tb_lcd_rx.sv
// Directed bench for lcd_rx. Busy windows are shortened through parameters so
// the run stays short with either tick length.
module tb_lcd_rx;

`ifdef LCD_RX_FAST_SIM_EN
  localparam int T = 4;
`else
  localparam int T = 1024;
`endif
  localparam int BL = 5;
  localparam int BS = 3;

  logic       clk_i = 1'b0;
  logic       rst_n_i = 1'b0;
  logic       rs_i = 1'b0;
  logic       en_i = 1'b0;
  logic [7:0] lcd_data_i = 8'h00;
  logic       evt_valid_o;
  logic       evt_ready_i = 1'b0;
  logic [3:0] evt_type_o;
  logic [7:0] evt_data_o;
  logic [6:0] evt_addr_o;
  logic       busy_o;
  logic       err_busy_o;
  logic       err_ovf_o;
  logic       err_clr_i = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  lcd_rx #(
    .DEPTH(4),
    .BUSY_LONG(BL),
    .BUSY_SHORT(BS)
  ) dut (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .rs_i       (rs_i),
    .en_i       (en_i),
    .lcd_data_i (lcd_data_i),
    .evt_valid_o(evt_valid_o),
    .evt_ready_i(evt_ready_i),
    .evt_type_o (evt_type_o),
    .evt_data_o (evt_data_o),
    .evt_addr_o (evt_addr_o),
    .busy_o     (busy_o),
    .err_busy_o (err_busy_o),
    .err_ovf_o  (err_ovf_o),
    .err_clr_i  (err_clr_i)
  );

  // Ends 1 ns after edge N+2, where en_i was lowered just before edge N.
  task automatic strobe_raw(input logic rs, input logic [7:0] d);
    rs_i = rs;
    lcd_data_i = d;
    en_i = 1'b1;
    repeat (4) @(posedge clk_i);
    #1 en_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
  endtask

  // Ends 1 ns after the capture edge N+3.
  task automatic strobe(input logic rs, input logic [7:0] d);
    strobe_raw(rs, d);
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy_o && n < 20000) begin
      @(posedge clk_i);
      #1;
      n++;
    end
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL wait_idle: busy_o got %b required 0 within bound", busy_o);
    end
  endtask

  task automatic send(input logic rs, input logic [7:0] d);
    strobe(rs, d);
    wait_idle();
  endtask

  task automatic pop_check(input string name, input logic [3:0] t, input logic [7:0] d,
                           input logic [6:0] a);
    checks++;
    if (evt_valid_o !== 1'b1) begin
      errors++;
      $display("FAIL %s valid: got %b required 1", name, evt_valid_o);
    end
    checks++;
    if (evt_type_o !== t) begin
      errors++;
      $display("FAIL %s type: got %0d required %0d", name, evt_type_o, t);
    end
    checks++;
    if (evt_data_o !== d) begin
      errors++;
      $display("FAIL %s data: got %h required %h", name, evt_data_o, d);
    end
    checks++;
    if (evt_addr_o !== a) begin
      errors++;
      $display("FAIL %s addr: got %h required %h", name, evt_addr_o, a);
    end
    evt_ready_i = 1'b1;
    @(posedge clk_i);
    #1 evt_ready_i = 1'b0;
  endtask

  task automatic send_pop(input string name, input logic rs, input logic [7:0] d,
                          input logic [3:0] t, input logic [6:0] a);
    send(rs, d);
    pop_check(name, t, d, a);
  endtask

  task automatic clr_pulse();
    err_clr_i = 1'b1;
    @(posedge clk_i);
    #1 err_clr_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0;
    en_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    checks++;
    if ({evt_valid_o, busy_o, err_busy_o, err_ovf_o} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got %b required 0000",
               {evt_valid_o, busy_o, err_busy_o, err_ovf_o});
    end
    checks++;
    if ({evt_type_o, evt_data_o, evt_addr_o} !== 19'd0) begin
      errors++;
      $display("FAIL reset_evt: got %h required 0", {evt_type_o, evt_data_o, evt_addr_o});
    end
    rst_n_i = 1'b1;
    repeat (8) @(posedge clk_i);
    #1;
    checks++;
    if ({evt_valid_o, busy_o} !== 2'b00) begin
      errors++;
      $display("FAIL reset_en_high: got valid/busy %b required 00", {evt_valid_o, busy_o});
    end
    rst_n_i = 1'b0;
    en_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 rst_n_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
  endtask

  task automatic test_clear_busy();
    strobe_raw(1'b0, 8'h01);
    checks++;
    if ({evt_valid_o, busy_o} !== 2'b00) begin
      errors++;
      $display("FAIL clear_n2: got valid/busy %b required 00", {evt_valid_o, busy_o});
    end
    @(posedge clk_i);
    #1;
    checks++;
    if ({evt_valid_o, busy_o} !== 2'b11) begin
      errors++;
      $display("FAIL clear_n3: got valid/busy %b required 11", {evt_valid_o, busy_o});
    end
    repeat (BL * T - 1) @(posedge clk_i);
    #1;
    checks++;
    if (busy_o !== 1'b1) begin
      errors++;
      $display("FAIL clear_busy_last: got %b required 1", busy_o);
    end
    @(posedge clk_i);
    #1;
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL clear_busy_end: got %b required 0", busy_o);
    end
    pop_check("clear_evt", 4'd1, 8'h01, 7'h00);
  endtask

  task automatic test_sequence();
    send_pop("seq_entry", 1'b0, 8'h06, 4'd3, 7'h00);
    send_pop("seq_ddram", 1'b0, 8'h80, 4'd8, 7'h00);
    send_pop("seq_char_a", 1'b1, 8'h41, 4'd9, 7'h00);
    send_pop("seq_char_b", 1'b1, 8'h42, 4'd9, 7'h01);
  endtask

  task automatic test_wrap();
    send_pop("wrap_ddram", 1'b0, 8'hA7, 4'd8, 7'h02);
    send_pop("wrap_c27", 1'b1, 8'h78, 4'd9, 7'h27);
    send_pop("wrap_c40", 1'b1, 8'h79, 4'd9, 7'h40);
    send_pop("wrap_dec", 1'b0, 8'h04, 4'd3, 7'h41);
    send_pop("wrap_d80", 1'b0, 8'h80, 4'd8, 7'h41);
    send_pop("wrap_c00", 1'b1, 8'h7A, 4'd9, 7'h00);
    send_pop("wrap_c67", 1'b1, 8'h7B, 4'd9, 7'h67);
  endtask

  task automatic test_cgram();
    send_pop("cg_inc", 1'b0, 8'h06, 4'd3, 7'h66);
    send_pop("cg_addr", 1'b0, 8'h7F, 4'd7, 7'h66);
    send_pop("cg_d3f", 1'b1, 8'h1F, 4'd10, 7'h3F);
    send_pop("cg_d00", 1'b1, 8'h11, 4'd10, 7'h00);
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 5; i++) send(1'b0, 8'h80 + 8'(i));
    checks++;
    if ({err_ovf_o, err_busy_o} !== 2'b10) begin
      errors++;
      $display("FAIL ovf_flags: got ovf/busy %b required 10", {err_ovf_o, err_busy_o});
    end
    pop_check("ovf_e0", 4'd8, 8'h80, 7'h01);
    pop_check("ovf_e1", 4'd8, 8'h81, 7'h00);
    pop_check("ovf_e2", 4'd8, 8'h82, 7'h01);
    pop_check("ovf_e3", 4'd8, 8'h83, 7'h02);
    checks++;
    if (evt_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL ovf_drained: got valid %b required 0", evt_valid_o);
    end
    clr_pulse();
    checks++;
    if (err_ovf_o !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear: got %b required 0", err_ovf_o);
    end
    // Dropped 0x84 still moved the address.
    send_pop("ovf_addr", 1'b1, 8'h55, 4'd9, 7'h04);
  endtask

  task automatic test_back_to_back();
    strobe(1'b0, 8'h38);
    strobe(1'b0, 8'h39);
    checks++;
    if ({err_busy_o, busy_o} !== 2'b11) begin
      errors++;
      $display("FAIL b2b_err: got err_busy/busy %b required 11", {err_busy_o, busy_o});
    end
    repeat (BS * T - 1) @(posedge clk_i);
    #1;
    checks++;
    if (busy_o !== 1'b1) begin
      errors++;
      $display("FAIL b2b_restart_last: got %b required 1", busy_o);
    end
    @(posedge clk_i);
    #1;
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL b2b_restart_end: got %b required 0", busy_o);
    end
    pop_check("b2b_e0", 4'd6, 8'h38, 7'h05);
    pop_check("b2b_e1", 4'd6, 8'h39, 7'h05);
    clr_pulse();
    checks++;
    if (err_busy_o !== 1'b0) begin
      errors++;
      $display("FAIL b2b_clear: got %b required 0", err_busy_o);
    end
  endtask

  initial begin
    test_reset();
    test_clear_busy();
    test_sequence();
    test_wrap();
    test_cgram();
    test_overflow();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
